id_ex_stage: RTL and testbench

- ID/EX pipeline stage for the 5-stage MIPS core with full forwarding and control-hazard handling.
- Captures the instruction decoder's control word (RegDst, DataC, RegWrite, Branch, MemRead, MemWrite, PCSrc, AluOperation, imm_en, signed_imm) and the decoded operands each cycle.
- Resolves the write-back register, extends the immediate, and detects load-use hazards, raising a stall to IF/ID and the PC.
- Inserts bubbles on stall or on a branch/jump flush from EX, and keeps saturating stall and flush counters.

---
 rtl/id_ex_stage.sv | 171 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register for the 5-stage MIPS core.
//
// Captures the decoder control word and decoded operands each cycle. It
// resolves the write-back register and extends the immediate. It detects
// load-use hazards and inserts bubbles on a stall or on an EX flush. It also
// keeps saturating stall and flush event counters.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   valid_i .. alu_op_i ID-slot instruction: operands, specifiers, controls
//   flush_i             EX resolved a taken branch/jump; kill the ID instruction
//   stall_o             combinational load-use stall to IF/ID and PC
//   valid_o .. alu_op_o registered EX-slot instruction
//   stall_cnt_o         saturating count of stall cycles not hidden by a flush
//   flush_cnt_o         saturating count of flushes that killed a valid instr
module id_ex_stage #(
    parameter int CNT_W    = 16,
    parameter int LINK_REG = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [31:0]      pc_plus4_i,
    input  logic [31:0]      rs_data_i,
    input  logic [31:0]      rt_data_i,
    input  logic [15:0]      imm_i,
    input  logic [4:0]       shamt_i,
    input  logic [4:0]       rs_i,
    input  logic [4:0]       rt_i,
    input  logic [4:0]       rd_i,
    input  logic             reg_dst_i,
    input  logic             data_c_i,
    input  logic             reg_write_i,
    input  logic             branch_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic             imm_en_i,
    input  logic             signed_imm_i,
    input  logic [1:0]       pc_src_i,
    input  logic [3:0]       alu_op_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [31:0]      pc_plus4_o,
    output logic [31:0]      rs_data_o,
    output logic [31:0]      rt_data_o,
    output logic [31:0]      imm_ext_o,
    output logic [4:0]       shamt_o,
    output logic [4:0]       rs_o,
    output logic [4:0]       rt_o,
    output logic [4:0]       wr_addr_o,
    output logic             data_c_o,
    output logic             reg_write_o,
    output logic             branch_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             imm_en_o,
    output logic [1:0]       pc_src_o,
    output logic [3:0]       alu_op_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_plus4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr_addr;
        logic        data_c;
        logic        reg_write;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        imm_en;
        logic [1:0]  pc_src;
        logic [3:0]  alu_op;
    } ex_t;

    ex_t              ex_d, ex_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic [4:0]       wr_addr;
    logic [31:0]      imm_ext;
    logic             uses_rt;
    logic             stall;

    always_comb begin
        // jal/jalr link through data_c; pc_src picks the link register
        wr_addr = rd_i;
        if (data_c_i && pc_src_i == 2'b01)      wr_addr = 5'(LINK_REG);
        else if (data_c_i && pc_src_i == 2'b10) wr_addr = rd_i;
        else if (reg_dst_i)                     wr_addr = rt_i;

        imm_ext = signed_imm_i ? {{16{imm_i[15]}}, imm_i} : {16'b0, imm_i};

        // rt is a source unless it is an immediate-form destination; stores read it
        uses_rt = ~imm_en_i | mem_write_i;
        stall   = rst_n & valid_i & ex_q.valid & ex_q.mem_read & (ex_q.wr_addr != 5'd0)
                & ((ex_q.wr_addr == rs_i) | (uses_rt & (ex_q.wr_addr == rt_i)));
    end

    always_comb begin
        ex_d           = '0;
        ex_d.valid     = valid_i;
        ex_d.pc_plus4  = pc_plus4_i;
        ex_d.rs_data   = rs_data_i;
        ex_d.rt_data   = rt_data_i;
        ex_d.imm_ext   = imm_ext;
        ex_d.shamt     = shamt_i;
        ex_d.rs        = rs_i;
        ex_d.rt        = rt_i;
        ex_d.wr_addr   = wr_addr;
        ex_d.data_c    = data_c_i;
        ex_d.imm_en    = imm_en_i;
        ex_d.alu_op    = alu_op_i;
        // side-effecting controls only travel with a valid instruction
        if (valid_i) begin
            ex_d.reg_write = reg_write_i;
            ex_d.branch    = branch_i;
            ex_d.mem_read  = mem_read_i;
            ex_d.mem_write = mem_write_i;
            ex_d.pc_src    = pc_src_i;
        end
        // flush or stall: an all-zero bubble
        if (flush_i || stall) ex_d = '0;

        stall_cnt_d = stall_cnt_q;
        if (stall && !flush_i && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (flush_i && valid_i && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_o     = stall;
    assign valid_o     = ex_q.valid;
    assign pc_plus4_o  = ex_q.pc_plus4;
    assign rs_data_o   = ex_q.rs_data;
    assign rt_data_o   = ex_q.rt_data;
    assign imm_ext_o   = ex_q.imm_ext;
    assign shamt_o     = ex_q.shamt;
    assign rs_o        = ex_q.rs;
    assign rt_o        = ex_q.rt;
    assign wr_addr_o   = ex_q.wr_addr;
    assign data_c_o    = ex_q.data_c;
    assign reg_write_o = ex_q.reg_write;
    assign branch_o    = ex_q.branch;
    assign mem_read_o  = ex_q.mem_read;
    assign mem_write_o = ex_q.mem_write;
    assign imm_en_o    = ex_q.imm_en;
    assign pc_src_o    = ex_q.pc_src;
    assign alu_op_o    = ex_q.alu_op;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed test of id_ex_stage. The counter width is reduced so that
// saturation is reachable in a few dozen cycles.
module tb_id_ex_stage;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i;
    logic [31:0]   pc_plus4_i, rs_data_i, rt_data_i;
    logic [15:0]   imm_i;
    logic [4:0]    shamt_i, rs_i, rt_i, rd_i;
    logic          reg_dst_i, data_c_i, reg_write_i, branch_i, mem_read_i, mem_write_i;
    logic          imm_en_i, signed_imm_i;
    logic [1:0]    pc_src_i;
    logic [3:0]    alu_op_i;
    logic          flush_i;
    logic          stall_o, valid_o;
    logic [31:0]   pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o;
    logic [4:0]    shamt_o, rs_o, rt_o, wr_addr_o;
    logic          data_c_o, reg_write_o, branch_o, mem_read_o, mem_write_o, imm_en_o;
    logic [1:0]    pc_src_o;
    logic [3:0]    alu_op_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    int n_chk = 0;
    int n_bad = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(CW), .LINK_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .pc_plus4_i(pc_plus4_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .shamt_i(shamt_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .reg_dst_i(reg_dst_i), .data_c_i(data_c_i),
        .reg_write_i(reg_write_i), .branch_i(branch_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .imm_en_i(imm_en_i), .signed_imm_i(signed_imm_i),
        .pc_src_i(pc_src_i), .alu_op_i(alu_op_i), .flush_i(flush_i), .stall_o(stall_o),
        .valid_o(valid_o), .pc_plus4_o(pc_plus4_o), .rs_data_o(rs_data_o),
        .rt_data_o(rt_data_o), .imm_ext_o(imm_ext_o), .shamt_o(shamt_o), .rs_o(rs_o),
        .rt_o(rt_o), .wr_addr_o(wr_addr_o), .data_c_o(data_c_o), .reg_write_o(reg_write_o),
        .branch_o(branch_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .imm_en_o(imm_en_o), .pc_src_o(pc_src_o), .alu_op_o(alu_op_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        valid_i = 0; pc_plus4_i = 0; rs_data_i = 0; rt_data_i = 0; imm_i = 0;
        shamt_i = 0; rs_i = 0; rt_i = 0; rd_i = 0; reg_dst_i = 0; data_c_i = 0;
        reg_write_i = 0; branch_i = 0; mem_read_i = 0; mem_write_i = 0; imm_en_i = 0;
        signed_imm_i = 0; pc_src_i = 0; alu_op_i = 0; flush_i = 0;
    endtask

    // lw $dst, 0($1)
    task automatic lw(input logic [4:0] dst);
        clr();
        valid_i = 1; rs_i = 5'd1; rt_i = dst; reg_dst_i = 1; mem_read_i = 1;
        imm_en_i = 1; signed_imm_i = 1; reg_write_i = 1; alu_op_i = 4'd2;
    endtask

    // add $8, $s, $t
    task automatic add(input logic [4:0] s, input logic [4:0] t);
        clr();
        valid_i = 1; rs_i = s; rt_i = t; rd_i = 5'd8; reg_write_i = 1; alu_op_i = 4'd2;
    endtask

    initial begin
        // reset with every input driven non-zero
        rst_n = 0; valid_i = 1; pc_plus4_i = 32'hAAAA_0004; rs_data_i = 32'h11;
        rt_data_i = 32'h22; imm_i = 16'hFFFF; shamt_i = 5'd3; rs_i = 5'd5; rt_i = 5'd5;
        rd_i = 5'd5; reg_dst_i = 1; data_c_i = 1; reg_write_i = 1; branch_i = 1;
        mem_read_i = 1; mem_write_i = 1; imm_en_i = 1; signed_imm_i = 1; pc_src_i = 2'b01;
        alu_op_i = 4'hF; flush_i = 1;
        #1 chk("rst_stall", {31'b0, stall_o}, 0);
        step();
        chk("rst_valid", {31'b0, valid_o}, 0);
        chk("rst_wr", {27'b0, wr_addr_o}, 0);
        chk("rst_imm", imm_ext_o, 0);
        chk("rst_ctl", {25'b0, reg_write_o, mem_read_o, mem_write_o, branch_o, pc_src_o, data_c_o}, 0);
        chk("rst_pc", pc_plus4_o, 0);
        chk("rst_cnt", {24'b0, stall_cnt_o, flush_cnt_o}, 0);
        chk("rst_stall2", {31'b0, stall_o}, 0);

        // add $3,$1,$2
        rst_n = 1; add(5'd1, 5'd2); rd_i = 5'd3;
        step();
        chk("add_wr", {27'b0, wr_addr_o}, 3);
        chk("add_rw", {31'b0, reg_write_o}, 1);
        chk("add_alu", {28'b0, alu_op_o}, 4'b0010);
        chk("add_valid", {31'b0, valid_o}, 1);

        // addi signed / ori unsigned
        clr(); valid_i = 1; imm_i = 16'hFFF0; signed_imm_i = 1; imm_en_i = 1; reg_dst_i = 1;
        rt_i = 5'd4; rd_i = 5'd9; reg_write_i = 1;
        step();
        chk("addi_imm", imm_ext_o, 32'hFFFF_FFF0);
        chk("addi_wr", {27'b0, wr_addr_o}, 4);
        signed_imm_i = 0;
        step();
        chk("ori_imm", imm_ext_o, 32'h0000_FFF0);

        // jal / jalr
        clr(); valid_i = 1; data_c_i = 1; pc_src_i = 2'b01; reg_write_i = 1; rd_i = 5'd0;
        reg_dst_i = 1; rt_i = 5'd6;
        step();
        chk("jal_wr", {27'b0, wr_addr_o}, 31);
        chk("jal_src", {30'b0, pc_src_o}, 1);
        pc_src_i = 2'b10; rd_i = 5'd7;
        step();
        chk("jalr_wr", {27'b0, wr_addr_o}, 7);

        // invalid slot clears controls
        clr(); reg_write_i = 1; mem_read_i = 1; pc_src_i = 2'b10; rd_i = 5'd9;
        step();
        chk("inv_ctl", {28'b0, reg_write_o, mem_read_o, pc_src_o}, 0);
        chk("inv_wr", {27'b0, wr_addr_o}, 9);

        // load-use on rs: one stall cycle, bubble, then add issues
        lw(5'd5);
        step();
        add(5'd5, 5'd6);
        #1 chk("lu_stall", {31'b0, stall_o}, 1);
        step(); exp_stall++;
        chk("lu_bubble", {31'b0, valid_o}, 0);
        chk("lu_bub_rw", {31'b0, reg_write_o}, 0);
        chk("lu_cnt", {28'b0, stall_cnt_o}, exp_stall);
        chk("lu_stall_drop", {31'b0, stall_o}, 0);
        step();
        chk("lu_issue_v", {31'b0, valid_o}, 1);
        chk("lu_issue_wr", {27'b0, wr_addr_o}, 8);

        // immediate-form rt match does not stall; store data on rt does
        lw(5'd5);
        step();
        clr(); valid_i = 1; rs_i = 5'd1; rt_i = 5'd5; imm_en_i = 1; reg_dst_i = 1;
        #1 chk("addi_rt_nostall", {31'b0, stall_o}, 0);
        mem_write_i = 1; reg_dst_i = 0;
        #1 chk("sw_rt_stall", {31'b0, stall_o}, 1);
        step(); exp_stall++;
        chk("sw_cnt", {28'b0, stall_cnt_o}, exp_stall);

        // load to $0 never stalls
        lw(5'd0);
        step();
        add(5'd0, 5'd0);
        #1 chk("r0_nostall", {31'b0, stall_o}, 0);
        step();
        chk("r0_valid", {31'b0, valid_o}, 1);

        // flush overrides a coincident stall
        lw(5'd5);
        step();
        add(5'd5, 5'd6); flush_i = 1;
        #1 chk("fl_stall_cond", {31'b0, stall_o}, 1);
        step();
        chk("fl_bubble", {31'b0, valid_o}, 0);
        chk("fl_cnt", {28'b0, flush_cnt_o}, 1);
        chk("fl_stall_cnt", {28'b0, stall_cnt_o}, exp_stall);

        // saturate the stall counter
        for (int i = 0; i < 20; i++) begin
            lw(5'd5);
            step();
            add(5'd5, 5'd0);
            step();
        end
        chk("sat_cnt", {28'b0, stall_cnt_o}, 15);

        // reset in the middle of a stall
        lw(5'd5);
        step();
        add(5'd5, 5'd0);
        #1 chk("mid_stall", {31'b0, stall_o}, 1);
        rst_n = 0; flush_i = 1;
        #1 chk("mid_rst_stall", {31'b0, stall_o}, 0);
        step();
        chk("mid_rst_valid", {31'b0, valid_o}, 0);
        chk("mid_rst_wr", {27'b0, wr_addr_o}, 0);
        chk("mid_rst_cnt", {24'b0, stall_cnt_o, flush_cnt_o}, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
